// File: rtl/ysyx_24110015_axil_sram.sv
// ysyx_24110015_axil_sram
// AXI4-Lite memory responder at the slave end of the core memory bus. Serves
// reads and writes from an internal word array; read and write channels are
// independent, each driven by its own two-process state machine.
//
// Parameters:
//   ADDR_BASE   - byte address of word 0
//   DEPTH_WORDS - number of 32-bit words (power of two, >= 2)
//   READ_LAT    - cycles from AR handshake to rvalid (>= 1)
//
// Ports:
//   clk, rst                         - clock; synchronous active-low reset
//   araddr/arvalid/arready           - read address channel
//   rdata/rresp/rvalid/rready        - read data channel (rresp 00 OKAY, 11 DECERR)
//   awaddr/awvalid/awready           - write address channel
//   wdata/wstrb/wvalid/wready        - write data channel (wstrb[i] -> byte i)
//   bresp/bvalid/bready              - write response channel
//
// Handshake rule: a transfer happens on a rising edge where valid and ready are
// both high. Outputs here are functions of registered state (plus rst), never
// of the valid/ready inputs, and an asserted valid is held until its handshake.
//
// Optional build macro: YSYX_24110015_AXIL_SRAM_DELAY_EN adds LFSR-driven random
// read/write latency and random ready hold-off for stress testing.
module ysyx_24110015_axil_sram #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          READ_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int          IW      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN    = 33'(DEPTH_WORDS) << 2;
    localparam int          CW      = 16;
    localparam logic [CW-1:0] RLAT_M1 = CW'(READ_LAT - 1);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    // Lower bound is checked separately: an address below the base wraps the
    // subtraction to a large offset that must not alias the top words.
    function automatic logic addr_ok(input logic [31:0] a);
        logic [31:0] off;
        off = a - ADDR_BASE;
        return (a >= ADDR_BASE) && ({1'b0, off} < SPAN);
    endfunction

    function automatic logic [IW-1:0] addr_idx(input logic [31:0] a);
        return IW'((a - ADDR_BASE) >> 2);
    endfunction

    logic [31:0] mem [DEPTH_WORDS];

    // ------------------------------------------------------------------
    // Optional random delay source
    // ------------------------------------------------------------------
    logic          hold_ready;
    logic [CW-1:0] rd_extra;
    logic [2:0]    wr_extra;

`ifdef YSYX_24110015_AXIL_SRAM_DELAY_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk) begin
        if (!rst) lfsr <= 8'hA5;
        else      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign hold_ready = lfsr[7];
    assign rd_extra   = CW'(lfsr[2:0]);
    assign wr_extra   = lfsr[5:3];
`else
    assign hold_ready = 1'b0;
    assign rd_extra   = '0;
    assign wr_extra   = '0;
`endif

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

    r_state_t      r_state, r_next;
    logic [CW-1:0] r_cnt, r_cnt_next, r_load;
    logic [31:0]   ar_addr_q, r_addr_sel;
    logic          ar_hs, r_sample;

    assign arready = rst && !hold_ready && (r_state == R_IDLE);
    assign rvalid  = (r_state == R_RESP);
    assign ar_hs   = arvalid && arready;
    assign r_load  = RLAT_M1 + rd_extra;

    // The counter holds the number of R_WAIT cycles still to spend; memory is
    // sampled on the edge that leaves the last one so rvalid lands at T+latency.
    always_comb begin
        r_next     = r_state;
        r_cnt_next = r_cnt;
        r_sample   = 1'b0;
        r_addr_sel = ar_addr_q;
        unique case (r_state)
            R_IDLE: begin
                if (ar_hs) begin
                    r_addr_sel = araddr;
                    if (r_load == '0) begin
                        r_sample = 1'b1;
                        r_next   = R_RESP;
                    end else begin
                        r_cnt_next = r_load;
                        r_next     = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_cnt <= CW'(1)) begin
                    r_sample = 1'b1;
                    r_next   = R_RESP;
                end else begin
                    r_cnt_next = r_cnt - CW'(1);
                end
            end
            R_RESP: begin
                if (rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= R_IDLE;
            r_cnt     <= '0;
            ar_addr_q <= '0;
            rdata     <= '0;
            rresp     <= RESP_OKAY;
        end else begin
            r_state <= r_next;
            r_cnt   <= r_cnt_next;
            if (ar_hs) ar_addr_q <= araddr;
            if (r_sample) begin
                if (addr_ok(r_addr_sel)) begin
                    rdata <= mem[addr_idx(r_addr_sel)];
                    rresp <= RESP_OKAY;
                end else begin
                    rdata <= '0;
                    rresp <= RESP_DECERR;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_DELAY, W_RESP} w_state_t;

    w_state_t    w_state, w_next;
    logic [2:0]  w_cnt, w_cnt_next;
    logic [31:0] aw_addr_q, w_data_q;
    logic [3:0]  w_strb_q;
    logic        aw_hs, w_hs, have_a, have_d, commit, c_ok;
    logic [31:0] c_addr, c_data;
    logic [3:0]  c_strb;

    assign awready = rst && !hold_ready && (w_state == W_IDLE || w_state == W_HAVE_D);
    assign wready  = rst && !hold_ready && (w_state == W_IDLE || w_state == W_HAVE_A);
    assign bvalid  = (w_state == W_RESP);
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    // Commit uses the live bus value for whichever half arrives this cycle and
    // the captured copy for the half that arrived earlier.
    assign have_a = (w_state == W_HAVE_A) || aw_hs;
    assign have_d = (w_state == W_HAVE_D) || w_hs;
    assign c_addr = (w_state == W_HAVE_A) ? aw_addr_q : awaddr;
    assign c_data = (w_state == W_HAVE_D) ? w_data_q  : wdata;
    assign c_strb = (w_state == W_HAVE_D) ? w_strb_q  : wstrb;
    assign c_ok   = addr_ok(c_addr);

    always_comb begin
        w_next     = w_state;
        w_cnt_next = w_cnt;
        commit     = 1'b0;
        unique case (w_state)
            W_IDLE, W_HAVE_A, W_HAVE_D: begin
                if (have_a && have_d) begin
                    commit = 1'b1;
                    if (wr_extra == 3'd0) begin
                        w_next = W_RESP;
                    end else begin
                        w_next     = W_DELAY;
                        w_cnt_next = wr_extra;
                    end
                end else if (aw_hs) begin
                    w_next = W_HAVE_A;
                end else if (w_hs) begin
                    w_next = W_HAVE_D;
                end
            end
            W_DELAY: begin
                if (w_cnt <= 3'd1) w_next = W_RESP;
                else               w_cnt_next = w_cnt - 3'd1;
            end
            W_RESP: begin
                if (bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            w_state   <= W_IDLE;
            w_cnt     <= '0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp     <= RESP_OKAY;
        end else begin
            w_state <= w_next;
            w_cnt   <= w_cnt_next;
            if (aw_hs) aw_addr_q <= awaddr;
            if (w_hs) begin
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            if (commit) bresp <= c_ok ? RESP_OKAY : RESP_DECERR;
        end
    end

    // Memory array: not reset. commit can only fire with a handshake in the
    // same cycle, and readys are low during reset, so reset blocks writes.
    always_ff @(posedge clk) begin
        if (commit && c_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (c_strb[i]) mem[addr_idx(c_addr)][8*i +: 8] <= c_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24110015_axil_sram.sv
// Directed bench for ysyx_24110015_axil_sram. Two instances share the write
// channel and read address: u_dut uses READ_LAT=1, u_dut3 uses READ_LAT=3 with
// its own arvalid/rready. Inputs change 1 time unit after a rising edge and
// outputs are checked at that same point, away from the edge.
module tb_ysyx_24110015_axil_sram;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] araddr, awaddr, wdata;
  logic [3:0]  wstrb;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic        arvalid3, rready3;

  logic [31:0] rdata, rdata3;
  logic [1:0]  rresp, rresp3, bresp, bresp3;
  logic        arready, rvalid, awready, wready, bvalid;
  logic        arready3, rvalid3, awready3, wready3, bvalid3;

  ysyx_24110015_axil_sram #(.READ_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  ysyx_24110015_axil_sram #(.READ_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid3), .arready(arready3),
    .rdata(rdata3), .rresp(rresp3), .rvalid(rvalid3), .rready(rready3),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready3),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready3),
    .bresp(bresp3), .bvalid(bvalid3), .bready(bready)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // Hold reset 4 cycles with every valid asserted; nothing may be accepted.
  task automatic do_reset(input logic [31:0] a, input logic [31:0] d);
    rst = 1'b0;
    araddr = a; awaddr = a; wdata = d; wstrb = 4'hF;
    arvalid = 1'b1; arvalid3 = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    rready = 1'b0; rready3 = 1'b0; bready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_arready", arready, 0);
      check("rst_awready", awready, 0);
      check("rst_wready", wready, 0);
    end
    rst = 1'b1;
    arvalid = 1'b0; arvalid3 = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    tick();
    check("post_arready", arready, 1);
    check("post_awready", awready, 1);
    check("post_wready", wready, 1);
    check("post_arready3", arready3, 1);
    check("post_rvalid", rvalid, 0);
    check("post_bvalid", bvalid, 0);
    check("post_rdata", rdata, 32'h0);
    check("post_rresp", rresp, 0);
    check("post_bresp", bresp, 0);
  endtask

  task automatic axi_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] exp_resp);
    check({tag, "_awready"}, awready, 1);
    check({tag, "_wready"}, wready, 1);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check({tag, "_bvalid"}, bvalid, 1);
    check({tag, "_bresp"}, bresp, exp_resp);
    check({tag, "_awready_busy"}, awready, 0);
    tick();
    check({tag, "_bvalid_clr"}, bvalid, 0);
  endtask

  task automatic axi_read(input string tag, input logic [31:0] a,
                          input logic [31:0] exp_d, input logic [1:0] exp_resp);
    check({tag, "_arready"}, arready, 1);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    check({tag, "_rvalid"}, rvalid, 1);
    check({tag, "_rdata"}, rdata, exp_d);
    check({tag, "_rresp"}, rresp, exp_resp);
    check({tag, "_arready_busy"}, arready, 0);
    tick();
    check({tag, "_rvalid_clr"}, rvalid, 0);
    check({tag, "_arready_back"}, arready, 1);
    rready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1;
    do_reset(32'h8000_0040, 32'hFFFF_FFFF);

    // Basic write/read with full strobes.
    axi_write("wr_full", 32'h8000_0010, 32'hDEADBEEF, 4'hF, 2'b00);
    axi_read("rd_full", 32'h8000_0010, 32'hDEADBEEF, 2'b00);

    // Byte strobes 0101: bytes 0 and 2 replaced.
    axi_write("wr_strb", 32'h8000_0010, 32'h11223344, 4'b0101, 2'b00);
    axi_read("rd_strb", 32'h8000_0010, 32'hDE22BE44, 2'b00);

    // AR handshake on the same edge as the write commit returns the old word.
    awaddr = 32'h8000_0010; wdata = 32'h55667788; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    araddr = 32'h8000_0010; arvalid = 1'b1; rready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("same_edge_rdata", rdata, 32'hDE22BE44);
    check("same_edge_bvalid", bvalid, 1);
    tick();
    rready = 1'b0;
    axi_read("rd_after_same", 32'h8000_0010, 32'h55667788, 2'b00);

    // Split handshakes: W first, AW three cycles later, bready held low.
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    tick();                                  // W handshake ("cycle 5")
    wvalid = 1'b0;
    check("split_wready_low", wready, 0);
    check("split_awready", awready, 1);
    check("split_no_bvalid", bvalid, 0);
    tick();
    tick();
    check("split_wait_bvalid", bvalid, 0);
    awaddr = 32'h8000_0030; awvalid = 1'b1;
    tick();                                  // AW handshake + commit ("cycle 8")
    awvalid = 1'b0;
    for (int c = 9; c <= 12; c++) begin
      check("split_bvalid_hold", bvalid, 1);
      check("split_bresp_hold", bresp, 0);
      check("split_awready_busy", awready, 0);
      if (c == 12) bready = 1'b1;
      tick();
    end
    check("split_bvalid_clr", bvalid, 0);
    bready = 1'b0;
    axi_read("rd_split", 32'h8000_0030, 32'hCAFEF00D, 2'b00);

    // Address range boundaries.
    axi_write("wr_top", 32'h8000_0FFC, 32'h0BADCAFE, 4'hF, 2'b00);
    axi_read("rd_oor_hi", 32'h8000_1000, 32'h0, 2'b11);
    axi_write("wr_oor_lo", 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 2'b11);
    axi_read("rd_top", 32'h8000_0FFC, 32'h0BADCAFE, 2'b00);
    axi_read("rd_ignore_lsb", 32'h8000_0FFF, 32'h0BADCAFE, 2'b00);

    // Reset mid-transaction must not write memory.
    axi_write("wr_pre_rst", 32'h8000_0020, 32'h12345678, 4'hF, 2'b00);
    do_reset(32'h8000_0020, 32'hFFFF_FFFF);
    axi_read("rd_post_rst", 32'h8000_0020, 32'h12345678, 2'b00);

    // READ_LAT=3 instance with rready held low for 4 cycles.
    check("l3_arready", arready3, 1);
    araddr = 32'h8000_0010; arvalid3 = 1'b1; rready3 = 1'b0;
    tick();                                  // AR handshake at T
    arvalid3 = 1'b0;
    check("l3_rvalid_t1", rvalid3, 0);
    check("l3_arready_t1", arready3, 0);
    tick();
    check("l3_rvalid_t2", rvalid3, 0);
    tick();
    for (int c = 3; c <= 6; c++) begin
      check("l3_rvalid_hold", rvalid3, 1);
      check("l3_rdata_hold", rdata3, 32'h55667788);
      check("l3_rresp_hold", rresp3, 0);
      check("l3_arready_busy", arready3, 0);
      if (c == 6) rready3 = 1'b1;
      tick();
    end
    rready3 = 1'b0;
    check("l3_rvalid_clr", rvalid3, 0);
    check("l3_arready_back", arready3, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_24110015_axil_sram.md
# ysyx_24110015_axil_sram

AXI4-Lite memory responder: accepts read and write transactions from the LSU/IFU bus initiators and serves them from an internal word-addressed register array. It sits at the slave end of the core's memory bus. Read and write channels run independently, each with its own state machine. It returns OKAY for in-range addresses and DECERR for out-of-range addresses.

## Interface
- ADDR_BASE, 32'h8000_0000, byte address of word 0
- DEPTH_WORDS, 1024, number of 32-bit words (power of two, ≥2)
- READ_LAT, 1, cycles from AR handshake to rvalid (≥1)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- araddr  in  32  read address
- arvalid  in  1  read address valid
- arready  out  1  read address accepted
- rdata  out  32  read data
- rresp  out  2  00 OKAY, 11 DECERR
- rvalid  out  1  read data valid
- rready  in  1  initiator accepts read data
- awaddr  in  32  write address
- awvalid  in  1  write address valid
- awready  out  1  write address accepted
- wdata  in  32  write data
- wstrb  in  4  byte enables, bit i → wdata[8i+7:8i]
- wvalid  in  1  write data valid
- wready  out  1  write data accepted
- bresp  out  2  00 OKAY, 11 DECERR
- bvalid  out  1  write response valid
- bready  in  1  initiator accepts response

## Operation
- Decode: in range iff ADDR_BASE ≤ addr < ADDR_BASE+4·DEPTH_WORDS; index = (addr−ADDR_BASE)[log2(DEPTH_WORDS)+1:2]; addr[1:0] ignored.
- Read FSM R_IDLE → R_WAIT → R_RESP → R_IDLE.
  - R_IDLE: arready=1. Handshake captures araddr and loads counter with READ_LAT−1; next state is R_WAIT, or R_RESP directly if READ_LAT=1.
  - R_WAIT: counter decrements. At 0, on the next edge, sample memory into rdata and enter R_RESP.
  - R_RESP: rvalid=1. rdata/rresp held stable until rready. The handshake returns the FSM to R_IDLE.
  - Out of range: rdata=0, rresp=11.
- Write FSM W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP.
  - awready=1 in W_IDLE/W_HAVE_D; wready=1 in W_IDLE/W_HAVE_A.
  - AW and W may handshake in either order or in the same cycle.
  - When both are held, the memory is written on that edge with the captured wstrb (in range only), and the FSM enters W_RESP.
  - W_RESP: bvalid=1, bresp=00 or 11 (out of range, no write). Handshake → W_IDLE.
- Memory contents are not reset.

## Timing
- Reset (rst=0 at edge): both FSMs idle; rvalid=0, bvalid=0, rdata=0, rresp=00, bresp=00.
  - arready, awready and wready are forced to 0 while rst=0, and read 1 on the first cycle after release.
- Reset mid-transaction aborts the transaction. No response is issued, and no memory write occurs unless the commit edge has already passed.
- Read latency: AR handshake in cycle T → rvalid high in cycle T+READ_LAT. At most one outstanding read; arready=0 from T+1 until the cycle after the R handshake.
- Write: the last of the AW/W handshakes in cycle T → memory updated at the end of T, bvalid high in T+1. A read whose data sample occurs on the same edge returns the old word.
- No back-to-back acceptance: after a handshake in cycle T, ready reasserts no earlier than T+2.
- Valid stays asserted until the handshake regardless of initiator behaviour; no combinational path from valid/ready inputs to outputs.

## Configuration
- YSYX_24110015_AXIL_SRAM_DELAY_EN defined: adds random latency for stress testing.
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on reset) advances every cycle.
  - At an AR handshake, lfsr[2:0] extra cycles are added to the R_WAIT count.
  - At a write commit, lfsr[5:3] extra cycles are spent in a hidden wait before bvalid.
  - arready/awready/wready are additionally held 0 while lfsr[7]=1 in idle.
- Undefined: fixed latency exactly as in Timing; no LFSR logic.

## Test plan
- Reset: hold rst=0 4 cycles with arvalid=awvalid=wvalid=1 → all readys 0, no memory write; after release arready=awready=wready=1, rvalid=bvalid=0.
- Write then read, READ_LAT=1: write 32'hDEADBEEF to 32'h8000_0010 with wstrb=4'hF, bready=1 → bvalid the cycle after the handshake, bresp=00. Read the same address → rvalid 1 cycle after AR, rdata=32'hDEADBEEF, rresp=00.
- Byte strobes: write 32'h11223344 with wstrb=4'b0101 over 32'hDEADBEEF → readback 32'hDE22BE44.
- Split and reordered handshakes: W at cycle 5, AW at cycle 8 → memory updated at cycle 8, bvalid at cycle 9. With bready low until cycle 12, bvalid and bresp stay stable through cycle 12.
- Out of range: read 32'h8000_1000 (DEPTH_WORDS=1024) → rdata=0, rresp=11. Write 32'h7FFF_FFFC → bresp=11, and a readback of index 1023 is unchanged.
- Latency/backpressure, READ_LAT=3, rready low 4 cycles → rvalid at T+3, rdata stable until handshake, arready low until the cycle after R handshake.
